// File: rtl/rv32_io_pkg.sv
// Shared definitions for the RV32 IO peripheral's pushbutton front end.
//   PB_COUNT            : number of board pushbuttons
//   PB_DEBOUNCE_DEFAULT : stable-sample count before a level change is accepted
//                         (10 ms at 50 MHz)
//   PB_ACTIVE_LOW       : 1 when a pressed button pulls its pin low
//   pb_state_e          : per-button debounce FSM state
package rv32_io_pkg;

    localparam int PB_COUNT            = 4;
    localparam int PB_DEBOUNCE_DEFAULT = 500000;
    localparam int PB_ACTIVE_LOW       = 1;

    typedef enum logic {
        PB_IDLE     = 1'b0,
        PB_COUNTING = 1'b1
    } pb_state_e;

endpackage : rv32_io_pkg

// File: rtl/pb_debounce_if.sv
// Signal bundle between the board pushbutton pins / IO block and the debouncer.
//   pb_raw     : asynchronous raw button pins
//   sticky_clr : per-bit clear of pb_sticky
//   pb_level   : debounced level, 1 = pressed
//   pb_press   : one-cycle pulse on an accepted press
//   pb_release : one-cycle pulse on an accepted release
//   pb_sticky  : set by a press, held until cleared
// master = pins/IO side, slave = debouncer.
interface pb_debounce_if
    import rv32_io_pkg::*;
#(
    parameter int N_BUTTONS = PB_COUNT
);

    logic [N_BUTTONS-1:0] pb_raw;
    logic [N_BUTTONS-1:0] sticky_clr;
    logic [N_BUTTONS-1:0] pb_level;
    logic [N_BUTTONS-1:0] pb_press;
    logic [N_BUTTONS-1:0] pb_release;
    logic [N_BUTTONS-1:0] pb_sticky;

    modport master (
        output pb_raw,
        output sticky_clr,
        input  pb_level,
        input  pb_press,
        input  pb_release,
        input  pb_sticky
    );

    modport slave (
        input  pb_raw,
        input  sticky_clr,
        output pb_level,
        output pb_press,
        output pb_release,
        output pb_sticky
    );

endinterface : pb_debounce_if

// File: rtl/pb_debounce_cell.sv
// One pushbutton: 2-flop synchroniser, polarity normalisation, debounce FSM
// with stability counter, registered press/release pulses and a sticky flag.
//   clk, reset  : system clock, synchronous active-high reset
//   pb_raw      : asynchronous raw pin
//   sticky_clr  : clears pb_sticky on the next edge (a same-edge press wins)
//   pb_level    : debounced level, 1 = pressed
//   pb_press    : high for the first cycle pb_level shows 1
//   pb_release  : high for the first cycle pb_level shows 0
//   pb_sticky   : set with pb_press, held until sticky_clr
module pb_debounce_cell
    import rv32_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT,
    parameter int ACTIVE_LOW      = PB_ACTIVE_LOW
) (
    input  logic clk,
    input  logic reset,
    input  logic pb_raw,
    input  logic sticky_clr,
    output logic pb_level,
    output logic pb_press,
    output logic pb_release,
    output logic pb_sticky
);

    // Counter only reaches DEBOUNCE_CYCLES-1, so this width never wraps.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Pin level of a released button; the synchroniser resets to it so
    // leaving reset never looks like an edge.
    localparam logic INACTIVE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             sync1_r;
    logic             sync2_r;
    pb_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;

    logic act_s;
    logic differ_s;
    logic accept_s;

    // Normalised pressed level and acceptance decision for this edge.
    always_comb begin
        act_s    = sync2_r ^ INACTIVE_LVL;
        differ_s = (act_s != pb_level);
        accept_s = 1'b0;
        case (state_r)
            PB_IDLE: begin
                // A one-sample debounce accepts on the first differing sample.
                if (differ_s && (DEBOUNCE_CYCLES == 1)) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            PB_COUNTING: begin
                if (differ_s && (cnt_r == CNT_LAST)) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // Synchroniser, debounce FSM, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r    <= INACTIVE_LVL;
            sync2_r    <= INACTIVE_LVL;
            state_r    <= PB_IDLE;
            cnt_r      <= CNT_ZERO;
            pb_level   <= 1'b0;
            pb_press   <= 1'b0;
            pb_release <= 1'b0;
            pb_sticky  <= 1'b0;
        end else begin
            sync1_r <= pb_raw;
            sync2_r <= sync1_r;

            if (accept_s) begin
                pb_level   <= act_s;
                pb_press   <= act_s;
                pb_release <= ~act_s;
                cnt_r      <= CNT_ZERO;
                state_r    <= PB_IDLE;
            end else begin
                pb_press   <= 1'b0;
                pb_release <= 1'b0;
                case (state_r)
                    PB_IDLE: begin
                        if (differ_s) begin
                            state_r <= PB_COUNTING;
                            cnt_r   <= CNT_ONE;
                        end else begin
                            cnt_r   <= CNT_ZERO;
                        end
                    end
                    PB_COUNTING: begin
                        if (differ_s) begin
                            cnt_r   <= cnt_r + CNT_ONE;
                        end else begin
                            // Input fell back before it was stable long enough.
                            state_r <= PB_IDLE;
                            cnt_r   <= CNT_ZERO;
                        end
                    end
                    default: begin
                        state_r <= PB_IDLE;
                        cnt_r   <= CNT_ZERO;
                    end
                endcase
            end

            // A press on the clearing edge takes priority so it is not lost.
            if (accept_s && act_s) begin
                pb_sticky <= 1'b1;
            end else if (sticky_clr) begin
                pb_sticky <= 1'b0;
            end else begin
                pb_sticky <= pb_sticky;
            end
        end
    end

endmodule : pb_debounce_cell

// File: rtl/pb_debounce.sv
// Pushbutton conditioner between the board pins and the RV32 IO block: one
// independent debounce cell per button.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : pb_debounce_if slave (pb_raw, sticky_clr in; pb_level,
//                pb_press, pb_release, pb_sticky out)
module pb_debounce
    import rv32_io_pkg::*;
#(
    parameter int N_BUTTONS       = PB_COUNT,
    parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT,
    parameter int ACTIVE_LOW      = PB_ACTIVE_LOW
) (
    input logic          clk,
    input logic          reset,
    pb_debounce_if.slave bus
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("pb_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [N_BUTTONS-1:0] level_s;
    logic [N_BUTTONS-1:0] press_s;
    logic [N_BUTTONS-1:0] release_s;
    logic [N_BUTTONS-1:0] sticky_s;

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_cell
        pb_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .pb_raw     (bus.pb_raw[g]),
            .sticky_clr (bus.sticky_clr[g]),
            .pb_level   (level_s[g]),
            .pb_press   (press_s[g]),
            .pb_release (release_s[g]),
            .pb_sticky  (sticky_s[g])
        );
    end

    assign bus.pb_level   = level_s;
    assign bus.pb_press   = press_s;
    assign bus.pb_release = release_s;
    assign bus.pb_sticky  = sticky_s;

endmodule : pb_debounce

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce (4 buttons, 4-sample debounce, active-low pins).
// A reference model steps on every rising edge and queues the expected
// outputs; a monitor on the falling edge pops and compares.
module tb_pb_debounce;

    localparam int NB = 4;
    localparam int DB = 4;
    localparam int AL = 1;

    typedef struct packed {
        logic [NB-1:0] level;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] sticky;
    } obs_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pb_debounce_if #(.N_BUTTONS(NB)) bus ();

    pb_debounce #(
        .N_BUTTONS       (NB),
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (AL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle    = 0;

    // Reference model: a button's pressed level flips once the pin (seen two
    // samples late through synchronisation) has disagreed with it for DB
    // consecutive edges.
    initial begin
        logic [NB-1:0] hist[$];
        int            run[NB];
        logic [NB-1:0] m_level;
        logic [NB-1:0] m_sticky;
        logic [NB-1:0] inact;
        logic          al_b;
        logic          act;
        obs_t          e;
        al_b     = (AL != 0);
        inact    = al_b ? {NB{1'b1}} : {NB{1'b0}};
        m_level  = '0;
        m_sticky = '0;
        hist     = '{inact, inact};
        for (int i = 0; i < NB; i++) run[i] = 0;
        forever begin
            @(posedge clk);
            e = '0;
            if (reset) begin
                m_level  = '0;
                m_sticky = '0;
                hist     = '{inact, inact};
                for (int i = 0; i < NB; i++) run[i] = 0;
            end else begin
                for (int i = 0; i < NB; i++) begin
                    act = hist[hist.size() - 2][i] ^ al_b;
                    if (act != m_level[i]) begin
                        run[i] = run[i] + 1;
                        if (run[i] == DB) begin
                            m_level[i] = act;
                            run[i]     = 0;
                            e.press[i] = act;
                            e.rel[i]   = ~act;
                        end
                    end else begin
                        run[i] = 0;
                    end
                    if (e.press[i])
                        m_sticky[i] = 1'b1;
                    else if (bus.sticky_clr[i])
                        m_sticky[i] = 1'b0;
                end
                hist.push_back(bus.pb_raw);
                while (hist.size() > 3) void'(hist.pop_front());
            end
            e.level  = m_level;
            e.sticky = m_sticky;
            exp_q.push_back(e);
            cycle++;
        end
    end

    // Monitor: every cycle the DUT presents a full output set.
    initial begin
        obs_t e;
        obs_t o;
        forever begin
            @(negedge clk);
            o.level  = bus.pb_level;
            o.press  = bus.pb_press;
            o.rel    = bus.pb_release;
            o.sticky = bus.pb_sticky;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_empty cyc=%0d got %h with nothing expected", cycle, o);
            end else begin
                e = exp_q.pop_front();
                if (o === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs cyc=%0d got level=%b press=%b rel=%b sticky=%b expected level=%b press=%b rel=%b sticky=%b",
                             cycle, o.level, o.press, o.rel, o.sticky,
                             e.level, e.press, e.rel, e.sticky);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus: directed scenarios followed by random bouncing.
    initial begin
        int hold[NB];
        reset          = 1'b1;
        bus.pb_raw     = {NB{1'b1}};
        bus.sticky_clr = {NB{1'b0}};
        cycles(3);
        reset = 1'b0;
        // idle pins, no activity expected
        cycles(20);
        // clean press on button 0
        bus.pb_raw[0] = 1'b0;
        cycles(10);
        // bouncing press on button 1
        bus.pb_raw[1] = 1'b0; cycles(3);
        bus.pb_raw[1] = 1'b1; cycles(1);
        bus.pb_raw[1] = 1'b0; cycles(2);
        bus.pb_raw[1] = 1'b1; cycles(1);
        bus.pb_raw[1] = 1'b0; cycles(12);
        // release button 0, then clear its sticky flag
        bus.pb_raw[0] = 1'b1;
        cycles(10);
        bus.sticky_clr[0] = 1'b1; cycles(1);
        bus.sticky_clr[0] = 1'b0; cycles(3);
        // buttons 2 and 3 together; clear of 2 lands on the accepting edge
        bus.pb_raw[2] = 1'b0;
        bus.pb_raw[3] = 1'b0;
        cycles(5);
        bus.sticky_clr[2] = 1'b1; cycles(1);
        bus.sticky_clr[2] = 1'b0; cycles(5);
        // reset in the middle of button 3's count, pin held through it
        bus.pb_raw[3] = 1'b1; cycles(10);
        bus.pb_raw[3] = 1'b0; cycles(4);
        reset = 1'b1; cycles(3);
        reset = 1'b0; cycles(12);
        // random bouncing, random clears, occasional reset
        bus.pb_raw = {NB{1'b1}};
        cycles(10);
        for (int i = 0; i < NB; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NB; i++) begin
                if (hold[i] == 0) begin
                    bus.pb_raw[i] = ~bus.pb_raw[i];
                    if ($urandom_range(0, 1) == 0)
                        hold[i] = int'($urandom_range(1, 3));
                    else
                        hold[i] = int'($urandom_range(4, 12));
                end else begin
                    hold[i] = hold[i] - 1;
                end
            end
            bus.sticky_clr = ($urandom_range(0, 7) == 0) ? NB'($urandom) : {NB{1'b0}};
            reset = ($urandom_range(0, 499) == 0);
        end
        reset          = 1'b0;
        bus.sticky_clr = {NB{1'b0}};
        cycles(20);
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pb_debounce
